uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_fifo.sv | 61 ++++++
 rtl/uart_tx_cfg.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM encoding,
// parity-mode constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Only the low nbits of data take part; the word is zero-extended to 9 bits.
    function automatic logic par_bit(input logic [8:0] data, input int nbits, input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Transmit FIFO: power-of-two depth, pointers carry one extra wrap bit so
// full and empty are distinguishable; flags are registered.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             full_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata    = mem_q[rd_ptr_q[AW-1:0]];
    assign full     = full_q;
    assign empty    = empty_q;
    assign full_nxt = full_d;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-fed frame sequencer with baud and bit
// counters, LSB-first shift register and optional even/odd parity.
//
// state | meaning
// IDLE  | line high, waiting for a queued word
// START | start bit (low) for CLK_DIV cycles
// DATA  | DATA_BITS data bits, LSB first
// PAR   | parity bit (skipped when PARITY == PAR_NONE)
// STOP  | STOP_BITS high bits, then next frame or IDLE
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_cfg: CLK_DIV must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 rdy_q, rdy_d;

    logic                 push, pop, start_frame, baud_done;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_full_nxt;

    assign push      = tx_valid && rdy_q && !fifo_full;
    assign baud_done = (baud_q == BAUD_LAST);

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wdata    (tx_data),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + BAUD_ONE;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) start_frame = 1'b1;
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (baud_done) begin
                    state_d = STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
        // Shared by IDLE and back-to-back STOP: pop and latch the next word.
        if (start_frame) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = fifo_rdata;
            par_d   = par_bit(9'(fifo_rdata), DATA_BITS, PARITY);
            tx_d    = 1'b0;
        end
    end

    assign pop    = start_frame;
    assign rdy_d  = !fifo_full_nxt;
    assign busy_d = push || (state_d != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_ready = rdy_q;

endmodule
